// File: rtl/dm_bytelane_if.sv
`default_nettype none
// ============================================================================
//  Module      : dm_bytelane_if
//  Description : Request/response bundle between the MEM stage and the
//                byte-lane data memory.
//                  mem_write, mem_read : store / load request this cycle
//                  op[2:0]             : access type (word/half/byte, signed)
//                  addr[31:0]          : byte address
//                  wdata[31:0]         : store data (low lanes for sh/sb)
//                  rdata[31:0]         : registered, extended load result
//                  rdata_valid         : rdata holds a new load result
//                  addr_err            : one-cycle pulse for a rejected access
//                  busy                : post-reset clear in progress
//  Revision    : 1.0 - initial release
// ============================================================================
interface dm_bytelane_if;
    logic        mem_write;
    logic        mem_read;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        addr_err;
    logic        busy;

    // Pipeline side: issues requests, consumes results.
    modport master (
        output mem_write, mem_read, op, addr, wdata,
        input  rdata, rdata_valid, addr_err, busy
    );

    // Memory side: consumes requests, produces results.
    modport slave (
        input  mem_write, mem_read, op, addr, wdata,
        output rdata, rdata_valid, addr_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/dm_bytelane.sv
`default_nettype none
// ============================================================================
//  Module      : dm_bytelane
//  Description : MEM-stage data memory with byte-lane-masked stores and
//                extended loads. After reset a clearing FSM zeroes every
//                word (one per cycle) before any access is accepted.
//  Ports       : clk   - system clock, rising edge
//                reset - synchronous, active-high reset
//                bus   - dm_bytelane_if.slave (requests in, results out)
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_bytelane #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  wire logic   clk,
    input  wire logic   reset,
    dm_bytelane_if.slave bus
);

    localparam logic [0:0]       c_CLEAR    = 1'b0;
    localparam logic [0:0]       c_READY    = 1'b1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rdata_valid_q, rdata_valid_d;
    logic             addr_err_q, addr_err_d;
    logic [31:0]      mem_q [0:DEPTH_WORDS-1];

    // FSM outputs
    logic w_busy;
    logic w_clear_en;

    // ------------------------------------------------------------------
    // Request decode and checks
    // ------------------------------------------------------------------
    logic             w_is_word, w_is_half, w_is_byte, w_op_rsvd;
    logic             w_misalign, w_out_of_range, w_err;
    logic             w_req, w_store_ok, w_load, w_load_ok;
    logic [IDX_W-1:0] w_idx;

    assign w_is_word      = (bus.op == 3'b000);
    assign w_is_half      = (bus.op == 3'b001) || (bus.op == 3'b010);
    assign w_is_byte      = (bus.op == 3'b011) || (bus.op == 3'b100);
    assign w_op_rsvd      = !(w_is_word || w_is_half || w_is_byte);
    assign w_misalign     = (w_is_word && (bus.addr[1:0] != 2'b00)) ||
                            (w_is_half && bus.addr[0]);
    assign w_out_of_range = (bus.addr[31:2] >= 30'(DEPTH_WORDS));
    assign w_err          = w_op_rsvd || w_misalign || w_out_of_range;
    assign w_idx          = bus.addr[IDX_W+1:2];

    // Requests only count once the clear has finished; a store wins over a
    // simultaneous load, which is then suppressed.
    assign w_req      = !w_busy && (bus.mem_write || bus.mem_read);
    assign w_store_ok = !w_busy && bus.mem_write && !w_err;
    assign w_load     = !w_busy && bus.mem_read && !bus.mem_write;
    assign w_load_ok  = w_load && !w_err;

    // ------------------------------------------------------------------
    // Clear FSM: state register / next-state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= c_CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            c_CLEAR: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == c_LAST_IDX) begin
                    state_d = c_READY;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = c_READY;
            end
        endcase
    end

    always_comb begin
        w_busy     = 1'b0;
        w_clear_en = 1'b0;
        case (state_q)
            c_CLEAR: begin
                w_busy     = 1'b1;
                w_clear_en = 1'b1;
            end
            default: begin
                w_busy     = 1'b0;
                w_clear_en = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Single write port shared by the clear sequence and stores.
    // Narrow store data is replicated across lanes so the byte enables
    // alone pick the destination lane.
    // ------------------------------------------------------------------
    logic             w_we;
    logic [IDX_W-1:0] w_widx;
    logic [31:0]      w_wdata;
    logic [3:0]       w_be;

    always_comb begin
        w_we    = 1'b0;
        w_widx  = '0;
        w_wdata = '0;
        w_be    = 4'b0000;
        if (reset) begin
            w_we = 1'b0;
        end else if (w_clear_en) begin
            w_we   = 1'b1;
            w_widx = idx_q;
            w_be   = 4'b1111;
        end else if (w_store_ok) begin
            w_we   = 1'b1;
            w_widx = w_idx;
            if (w_is_word) begin
                w_be    = 4'b1111;
                w_wdata = bus.wdata;
            end else if (w_is_half) begin
                w_be    = bus.addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{bus.wdata[15:0]}};
            end else begin
                w_be    = 4'b0001 << bus.addr[1:0];
                w_wdata = {4{bus.wdata[7:0]}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    mem_q[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Load path: read the old word, pick the lane, extend, register.
    // ------------------------------------------------------------------
    logic [31:0] w_rword;
    logic [15:0] w_rhalf;
    logic [7:0]  w_rbyte;
    logic [31:0] w_ext;

    assign w_rword = mem_q[w_idx];
    assign w_rhalf = bus.addr[1] ? w_rword[31:16] : w_rword[15:0];
    assign w_rbyte = w_rword[{bus.addr[1:0], 3'b000} +: 8];

    always_comb begin
        w_ext = w_rword;
        case (bus.op)
            3'b001:  w_ext = {16'h0000, w_rhalf};
            3'b010:  w_ext = {{16{w_rhalf[15]}}, w_rhalf};
            3'b011:  w_ext = {24'h000000, w_rbyte};
            3'b100:  w_ext = {{24{w_rbyte[7]}}, w_rbyte};
            default: w_ext = w_rword;
        endcase
    end

    // A rejected load clears rdata; everything else that is not a good
    // load leaves rdata untouched.
    always_comb begin
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        addr_err_d    = w_req && w_err;
        if (w_load_ok) begin
            rdata_d       = w_ext;
            rdata_valid_d = 1'b1;
        end else if (w_load) begin
            rdata_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            addr_err_q    <= addr_err_d;
        end
    end

    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.addr_err    = addr_err_q;
    assign bus.busy        = w_busy;

endmodule
`default_nettype wire

// File: doc/dm_bytelane.md
Name: dm_bytelane

Overview:
- Data-memory block for the MEM stage of the pipelined MIPS core.
- Stores: sw writes a full word; sh and sb perform byte-lane-masked partial writes.
- Loads: lw, lh, lhu, lb and lbu read a word, then extract and extend the addressed lane into a registered read result for the MEM/WB boundary.
- After reset, a clearing state machine zeroes the array before any access is accepted.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array; word index is addr[11:2] at the default depth.
IDX_W, 10, word-index width, equal to log2(DEPTH_WORDS).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
mem_write  input  1  store request this cycle.
mem_read  input  1  load request this cycle.
op  input  3  access type: 000 word, 001 half unsigned, 010 half signed, 011 byte unsigned, 100 byte signed; 101-111 reserved.
addr  input  32  byte address.
wdata  input  32  store data; halfword stores use wdata[15:0], byte stores use wdata[7:0].
rdata  output  32  registered, extended load result.
rdata_valid  output  1  high for one cycle when rdata holds a new load result.
addr_err  output  1  one-cycle pulse flagging a misaligned, out-of-range or reserved-op access.
busy  output  1  high while the post-reset clear runs; all requests are ignored while high.

Behaviour:
- Reset: clk and reset as named above; reset is synchronous and active-high.
  - Reset values: rdata=0, rdata_valid=0, addr_err=0, busy=1.
  - Reset sets the clear index to 0 and the FSM to CLEAR.
  - Reset asserted mid-clear restarts the clear from index 0.
  - Reset asserted mid-operation drops the pending access with no write.
- FSM, two states:
  - CLEAR: each cycle write 0 to word[idx] and increment idx. On the cycle that writes idx = DEPTH_WORDS-1, go to READY. busy=1 throughout CLEAR, so the clear takes exactly DEPTH_WORDS cycles after reset deasserts.
  - READY: busy=0; service requests. READY leaves only via reset.
- Address checks, evaluated only in READY when mem_write or mem_read is high:
  - misaligned: word access with addr[1:0]!=0, or halfword access with addr[0]!=0;
  - out of range: addr[31:2] >= DEPTH_WORDS;
  - reserved op: op = 101-111.
  - Any check failing: no array write; rdata and rdata_valid behave as described under load and idle below; addr_err=1 on the next cycle.
- Lane mapping (little-endian):
  - byte k = addr[1:0] occupies bits [8k+7:8k];
  - halfword h = addr[1] occupies bits [16h+15:16h].
- Store: on the edge, only the addressed lanes of word[addr[IDX_W+1:2]] are updated; other lanes are unchanged. Store has zero cycles of visible latency.
- Load, with latency 1: the value sampled at edge N appears on rdata, with rdata_valid=1, after edge N.
  - Unsigned ops zero-extend the lane; signed ops sign-extend from the lane MSB; word ops pass the word through.
  - A load whose checks fail produces rdata=0, rdata_valid=0 and addr_err=1.
- Idle cycles and busy cycles: rdata holds its previous value; rdata_valid=0.
- mem_write and mem_read both high: the store is performed and the read is suppressed (rdata_valid=0).
- Read-after-write: a load to the same address in the cycle after a store returns the newly stored data. The array is read-old/write-new within a cycle; there is no same-cycle bypass because simultaneous requests are excluded.
- Width rule: all extension is to 32 bits; no arithmetic is performed on data.

Test Plan:
- Clear sequence: reset for 2 cycles, then release.
  - busy=1 for exactly 1024 cycles, then 0.
  - lw from 0x0 and from 0xFFC both return 0x00000000.
  - Assert reset at clear index 500: busy stays high for a further 1024 cycles.
- Lane stores:
  - sw 0x11223344 to 0x10, then sb 0xAA to 0x12, then sh 0xBEEF to 0x10.
  - lw 0x10 returns 0x11AABEEF.
- Extension (word at 0x20 = 0x80FF7F01):
  - lb 0x23 returns 0xFFFFFF80;
  - lbu 0x23 returns 0x00000080;
  - lh 0x22 returns 0xFFFF80FF;
  - lhu 0x20 returns 0x00007F01;
  - lb 0x20 returns 0x00000001.
  - Each result appears one cycle later with rdata_valid=1.
- Errors:
  - sw to 0x21: addr_err pulses, word 0x20 is unchanged.
  - lh 0x23: addr_err=1, rdata_valid=0.
  - lw 0x1000 (out of range): addr_err=1.
  - op=110: addr_err=1.
- Back-to-back: sw 0xCAFEBABE to 0x40 at cycle N, lw 0x40 at cycle N+1; rdata is 0xCAFEBABE after edge N+1.
- Simultaneous request: mem_write=mem_read=1 with sw 0x5 to 0x44; rdata_valid=0, and a later lw 0x44 returns 0x00000005.
